dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Responder end of the pipeline MEM-stage data-memory interface: accepts the load/store
//  requests the core issues (memwrite/memread, aluout address, WriteDataM), models a
//  fixed-latency word RAM, and drives the stall request the hazard logic folds into StallF/StallD.
//  Sits beside top's datapath in place of the zero-wait data memory; benches use it to exercise stalls.
// PARAMETERS
//  DEPTH        64  number of 32-bit words; valid word index 0..DEPTH-1
//  WAIT_CYCLES  2   stall cycles per accepted access; legal range 1..15
// PORTS
//  clk       in   1   single clock, all state updates on rising edge
//  reset     in   1   synchronous, active-low: sampled 0 at a rising edge resets the block
//  memread   in   1   load request from MEM stage; held stable by core while stall=1
//  memwrite  in   1   store request from MEM stage; held stable by core while stall=1
//  addr      in   32  byte address (aluout); word index = addr[31:2]
//  wdata     in   32  store data (WriteDataM)
//  rdata     out  32  load data, valid when rvalid=1
//  rvalid    out  1   one-cycle pulse: access completed this cycle (loads and stores)
//  stall     out  1   combinational: core must hold MEM stage this cycle
//  err       out  1   one-cycle pulse: request rejected (misaligned, out of range, read+write)
//  acc_count out  16  completed-access counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rdata=0, rvalid=0, err=0, acc_count=0; stall=0 in reset cycle.
//   RAM contents not cleared. Reset mid-access abandons it: no write, no rvalid.
//  req = memread|memwrite. bad = (memread&memwrite) | addr[1:0]!=0 | addr[31:2]>=DEPTH.
//  FSM states IDLE, WAIT, DONE:
//   IDLE: stall = req & ~bad. At edge: bad&req -> err=1 next cycle, stay IDLE, no access;
//         req&~bad -> latch op/addr/wdata; WAIT_CYCLES==1 -> perform access, go DONE;
//         else go WAIT, cnt=WAIT_CYCLES-2.
//   WAIT: stall=1. At edge: ~req (core flushed) -> IDLE, no access, no rvalid;
//         cnt==0 -> perform access, go DONE; else cnt-1.
//   DONE: stall=0, rvalid=1, rdata=RAM[idx] for loads (0 for stores), acc_count already +1.
//         Request still visible this cycle is ignored; unconditionally -> IDLE.
//  Net timing: WAIT_CYCLES stall cycles, then one DONE cycle in which the core advances.
//  Back-to-back accesses: earliest next request accepted in IDLE cycle after DONE.
//  Store commits at the DONE-entry edge; a load of the same word after it returns new data.
//  err never asserts stall; rvalid and err never high in same cycle.
//  rvalid, err are registered; stall is the only combinational output.
// STRUCTURE
//  Package dmem_pkg: state_e {IDLE, WAIT, DONE} enum, WORD_W=32, CNT_W=4, acc_count width.
//  Sub-module dmem_array: single-port word RAM, sync write enable, registered read, DEPTH param.
//  dmem_responder holds FSM, request latch, cnt, acc_count, error detection.
// TESTING
//  1 reset low 2 edges -> rdata=0, rvalid=0, err=0, stall=0, acc_count=0.
//  2 memwrite addr=0x10 wdata=0xDEADBEEF, WAIT_CYCLES=2 -> stall high 2 cycles, rvalid next cycle;
//    then memread addr=0x10 -> rdata=0xDEADBEEF with rvalid, acc_count=2.
//  3 memread addr=0x13 -> err=1 one cycle, stall=0 throughout, acc_count unchanged;
//    addr=0x100 (DEPTH=64) -> err; memread&memwrite -> err.
//  4 memwrite addr=0x20 wdata=0x1234, drop memwrite during WAIT -> returns IDLE, no rvalid;
//    read 0x20 -> previous contents, not 0x1234.
//  5 reset low during WAIT of store to 0x24 -> no write, all outputs at reset values next cycle.
//  6 preload acc_count via 65535 accesses, one more -> acc_count=0, rvalid=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 4;
    localparam int ACC_CNT_W = 16;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous write and registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     a,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[a] <= wd;
        rd_q <= mem_q[a];
    end

    assign rd = rd_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM stage;
// stalls the core WAIT_CYCLES per access and flags rejected requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ACC_W       = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    output logic             stall,
    output logic             err,
    output logic [ACC_W-1:0] acc_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wd_q, wd_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              req, bad, accept, access, ram_we;
    logic [AW-1:0]     ram_idx;
    logic [WORD_W-1:0] ram_wd, ram_rd;

    always_comb begin
        req      = memread | memwrite;
        bad      = (memread & memwrite) | (addr[1:0] != 2'b00) | (32'(addr[31:2]) >= DEPTH);
        accept   = (state_q == IDLE) & req & ~bad;
        access   = (accept & (WAIT_CYCLES == 1)) | ((state_q == WAIT) & req & (cnt_q == '0));
        state_d  = (state_q == DONE) ? IDLE
                 : (state_q == WAIT) ? (!req ? IDLE : (cnt_q == '0) ? DONE : WAIT)
                 : accept ? ((WAIT_CYCLES == 1) ? DONE : WAIT) : IDLE;
        cnt_d    = accept ? CNT_W'(WAIT_CYCLES - 2)
                 : (state_q == WAIT) ? cnt_q - CNT_W'(1) : cnt_q;
        wr_d     = accept ? memwrite : wr_q;
        idx_d    = accept ? addr[AW+1:2] : idx_q;
        wd_d     = accept ? wdata : wd_q;
        rvalid_d = access;
        err_d    = (state_q == IDLE) & req & bad;
        acc_d    = acc_q + ACC_W'(access);
        // A single-cycle access fires from IDLE, before the request is latched.
        ram_idx  = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
        ram_wd   = (state_q == IDLE) ? wdata : wd_q;
        ram_we   = reset & access & ((state_q == IDLE) ? memwrite : wr_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk (clk),
        .we  (ram_we),
        .a   (ram_idx),
        .wd  (ram_wd),
        .rd  (ram_rd)
    );

    assign rdata     = (state_q == DONE && !wr_q) ? ram_rd : '0;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign acc_count = acc_q;
    assign stall     = reset & ((state_q == WAIT) | accept);
endmodule
